// File: rtl/sdcard_cmd_responder.sv
// SD/eMMC card-side CMD line responder: deframes and CRC7-checks host commands, then
// serializes a user R1/R2 response after NCR_MIN card-clock rises (pin-to-output ~4 i_clk).
module sdcard_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_sd_ck,
  input  logic         i_cmd,
  output logic         o_cmd,
  output logic         o_cmd_oe,
  output logic         o_cmd_valid,
  output logic         o_cmd_err,
  output logic [5:0]   o_cmd_idx,
  output logic [31:0]  o_cmd_arg,
  input  logic         i_rsp_valid,
  output logic         o_rsp_ready,
  input  logic         i_rsp_long,
  input  logic [119:0] i_rsp_data,
  output logic         o_rsp_timeout,
  output logic         o_busy
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) c = crc7_next(c, d[i]);
    return c;
  endfunction

  logic ck_s1, ck_s2, ck_prev, cmd_s1, cmd_s2;
  logic rise, fall;

  state_t             state_q, state_d;
  logic [5:0]         bit_cnt;
  logic [6:0]         crc_q;
  logic [45:0]        rx_sr;
  logic [NCR_W-1:0]   ncr_cnt;
  logic               latched;
  logic [135:0]       tx_sr;
  logic               tx_long;
  logic [7:0]         tx_cnt;

  logic               end_bit, rx_err, hs, timeout_hit, tx_start, tx_done;
  logic [119:0]       crc_in;
  logic [6:0]         rsp_crc;
  logic [135:0]       rsp_frame;

  assign rise = ck_s2 & ~ck_prev;
  assign fall = ~ck_s2 & ck_prev;

  assign end_bit     = (state_q == RX) && rise && (bit_cnt == 6'd47);
  assign rx_err      = (crc_q != rx_sr[6:0]) || !rx_sr[45] || !cmd_s2;
  assign hs          = i_rsp_valid & o_rsp_ready;
  assign timeout_hit = (state_q == WAIT) && rise && !latched && !hs &&
                       (ncr_cnt == NCR_W'(NCR_MAX - 1));
  assign tx_start    = (state_q == WAIT) && fall && latched && (ncr_cnt >= NCR_W'(NCR_MIN));
  assign tx_done     = (state_q == TX) && fall && (tx_cnt == (tx_long ? 8'd136 : 8'd48));
  assign o_busy      = (state_q != IDLE);

  // Zero-padding the short payload leaves the CRC unchanged, so one CRC engine serves both frames.
  assign crc_in    = i_rsp_long ? i_rsp_data : {82'd0, i_rsp_data[37:0]};
  assign rsp_crc   = crc7_120(crc_in);
  assign rsp_frame = i_rsp_long ? {2'b00, 6'h3F, i_rsp_data, rsp_crc, 1'b1}
                                : {2'b00, i_rsp_data[37:0], rsp_crc, 1'b1, 88'd0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise && !cmd_s2) state_d = RX;
      RX:      if (end_bit) state_d = rx_err ? IDLE : WAIT;
      WAIT: begin
        if (timeout_hit)   state_d = IDLE;
        else if (tx_start) state_d = TX;
      end
      TX:      if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ck_s1         <= 1'b0;
      ck_s2         <= 1'b0;
      ck_prev       <= 1'b0;
      cmd_s1        <= 1'b1;
      cmd_s2        <= 1'b1;
      state_q       <= IDLE;
      bit_cnt       <= '0;
      crc_q         <= '0;
      rx_sr         <= '0;
      ncr_cnt       <= '0;
      latched       <= 1'b0;
      tx_sr         <= '0;
      tx_long       <= 1'b0;
      tx_cnt        <= '0;
      o_cmd         <= 1'b1;
      o_cmd_oe      <= 1'b0;
      o_cmd_valid   <= 1'b0;
      o_cmd_err     <= 1'b0;
      o_cmd_idx     <= '0;
      o_cmd_arg     <= '0;
      o_rsp_ready   <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      ck_s1         <= i_sd_ck;
      ck_s2         <= ck_s1;
      ck_prev       <= ck_s2;
      cmd_s1        <= i_cmd;
      cmd_s2        <= cmd_s1;
      state_q       <= state_d;
      o_cmd_valid   <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_ready   <= (state_q == WAIT) && (state_d == WAIT) && !latched && !hs;

      case (state_q)
        IDLE: begin
          if (rise && !cmd_s2) begin
            bit_cnt <= 6'd1;
            crc_q   <= '0;
          end
        end
        RX: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            rx_sr   <= {rx_sr[44:0], cmd_s2};
            // Bits 46..8 feed the CRC; the start bit is 0 and leaves a cleared CRC unchanged.
            if (bit_cnt <= 6'd39) crc_q <= crc7_next(crc_q, cmd_s2);
            if (end_bit) begin
              o_cmd_valid <= 1'b1;
              o_cmd_err   <= rx_err;
              o_cmd_idx   <= rx_sr[44:39];
              o_cmd_arg   <= rx_sr[38:7];
              ncr_cnt     <= '0;
              latched     <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (rise && (ncr_cnt != NCR_W'(NCR_MAX))) ncr_cnt <= ncr_cnt + NCR_W'(1);
          if (hs) begin
            latched <= 1'b1;
            tx_sr   <= rsp_frame;
            tx_long <= i_rsp_long;
          end
          if (timeout_hit) o_rsp_timeout <= 1'b1;
          if (tx_start) begin
            o_cmd    <= tx_sr[135];
            o_cmd_oe <= 1'b1;
            tx_sr    <= {tx_sr[134:0], 1'b0};
            tx_cnt   <= 8'd1;
          end
        end
        TX: begin
          if (fall) begin
            if (tx_done) begin
              o_cmd_oe <= 1'b0;
              o_cmd    <= 1'b1;
            end else begin
              o_cmd  <= tx_sr[135];
              tx_sr  <= {tx_sr[134:0], 1'b0};
              tx_cnt <= tx_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Directed bench for sdcard_cmd_responder: host-side CMD/CK driver, response capture and
// a table of command vectors plus hand-written response, long-response and reset sequences.
module tb_sdcard_cmd_responder;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_sd_ck = 1'b0;
  logic         i_cmd = 1'b1;
  logic         i_rsp_valid = 1'b0;
  logic         i_rsp_long = 1'b0;
  logic [119:0] i_rsp_data = '0;
  logic         o_cmd, o_cmd_oe, o_cmd_valid, o_cmd_err, o_rsp_ready, o_rsp_timeout, o_busy;
  logic [5:0]   o_cmd_idx;
  logic [31:0]  o_cmd_arg;

  sdcard_cmd_responder #(.NCR_MIN(2), .NCR_MAX(64)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sd_ck(i_sd_ck), .i_cmd(i_cmd),
    .o_cmd(o_cmd), .o_cmd_oe(o_cmd_oe), .o_cmd_valid(o_cmd_valid), .o_cmd_err(o_cmd_err),
    .o_cmd_idx(o_cmd_idx), .o_cmd_arg(o_cmd_arg), .i_rsp_valid(i_rsp_valid),
    .o_rsp_ready(o_rsp_ready), .i_rsp_long(i_rsp_long), .i_rsp_data(i_rsp_data),
    .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [47:0] frame;
    logic        exp_err;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[5];

  int checks = 0, failures = 0;
  int cur_cycle = 0, end_cycle = 0, to_off = -1, valid_cnt = 0, to_cnt = 0, rsp_count = 0, rsp_start = -1;
  logic         got_err, prev_valid, ready_at_valid, ready_after_valid, ready_seen, oe_seen;
  logic [5:0]   got_idx;
  logic [31:0]  got_arg;
  logic [135:0] rsp_bits;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC7 (x^7+x^3+1), bit-serial, MSB first over a zero-padded 120-bit field.
  function automatic logic [6:0] ref_crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'b0001001;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, ref_crc7({80'd0, h}), 1'b1};
  endfunction

  task automatic clear_stats();
    valid_cnt = 0; to_cnt = 0; to_off = -1; rsp_count = 0; rsp_start = -1; rsp_bits = '0;
    prev_valid = 1'b0; ready_at_valid = 1'b0; ready_after_valid = 1'b0;
    ready_seen = 1'b0; oe_seen = 1'b0;
    got_err = 1'b0; got_idx = '0; got_arg = '0;
  endtask

  task automatic tick();
    logic hs;
    hs = i_rsp_valid && o_rsp_ready;
    @(posedge i_clk);
    #1;
    if (hs) i_rsp_valid = 1'b0;
    if (prev_valid) ready_after_valid = o_rsp_ready;
    prev_valid = o_cmd_valid;
    if (o_cmd_valid) begin
      valid_cnt++;
      got_err = o_cmd_err; got_idx = o_cmd_idx; got_arg = o_cmd_arg;
      ready_at_valid = o_rsp_ready;
    end
    if (o_rsp_ready) ready_seen = 1'b1;
    if (o_rsp_timeout) begin to_cnt++; to_off = cur_cycle - end_cycle; end
    if (o_cmd_oe) oe_seen = 1'b1;
  endtask

  // One SD clock period (16 i_clk); the card's CMD output is sampled just before the rise.
  task automatic sd_cycle(input logic b);
    cur_cycle++;
    i_cmd = b;
    i_sd_ck = 1'b0;
    repeat (8) tick();
    if (o_cmd_oe) begin
      if (rsp_count == 0) rsp_start = cur_cycle - end_cycle;
      rsp_bits = {rsp_bits[134:0], o_cmd};
      rsp_count++;
    end
    i_sd_ck = 1'b1;
    repeat (8) tick();
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) sd_cycle(f[i]);
    end_cycle = cur_cycle;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sd_cycle(1'b1);
  endtask

  logic [47:0]  f;
  logic [119:0] long_d;
  logic [39:0]  short_h;
  logic [47:0]  exp_short;
  logic [135:0] exp_long;

  initial begin
    clear_stats();
    repeat (4) tick();
    check("reset_cmd", 136'(o_cmd), 136'(1'b1));
    check("reset_oe", 136'(o_cmd_oe), 136'(1'b0));
    check("reset_valid_err", 136'({o_cmd_valid, o_cmd_err}), 136'(2'b00));
    check("reset_idx_arg", 136'({o_cmd_idx, o_cmd_arg}), 136'(38'd0));
    check("reset_rdy_to_busy", 136'({o_rsp_ready, o_rsp_timeout, o_busy}), 136'(3'b000));
    i_reset_n = 1'b1;
    repeat (4) tick();

    // Command vectors with no response offered: valid ones must time out after 64 rises.
    vecs[0] = '{48'h40_0000_0000_95, 1'b0, 6'd0, 32'h0000_0000};
    vecs[1] = '{48'h51_0000_0000_54, 1'b1, 6'd17, 32'h0000_0000};
    vecs[2] = '{mk_cmd(6'd41, 32'h40FF_8000), 1'b0, 6'd41, 32'h40FF_8000};
    f = mk_cmd(6'd55, 32'h0); f[46] = 1'b0;
    vecs[3] = '{f, 1'b1, 6'd55, 32'h0000_0000};
    f = mk_cmd(6'd9, 32'h1234_0000); f[20] = ~f[20];
    vecs[4] = '{f, 1'b1, 6'd9, 32'h1234_1000};

    for (int v = 0; v < 5; v++) begin
      clear_stats();
      send_cmd(vecs[v].frame);
      idle(70);
      check($sformatf("v%0d_valid_cnt", v), 136'(valid_cnt), 136'(1));
      check($sformatf("v%0d_err", v), 136'(got_err), 136'(vecs[v].exp_err));
      check($sformatf("v%0d_idx", v), 136'(got_idx), 136'(vecs[v].exp_idx));
      check($sformatf("v%0d_arg", v), 136'(got_arg), 136'(vecs[v].exp_arg));
      check($sformatf("v%0d_ready_at_valid", v), 136'(ready_at_valid), 136'(1'b0));
      check($sformatf("v%0d_ready_after_valid", v), 136'(ready_after_valid), 136'(!vecs[v].exp_err));
      check($sformatf("v%0d_timeouts", v), 136'(to_cnt), 136'(vecs[v].exp_err ? 0 : 1));
      if (!vecs[v].exp_err) check($sformatf("v%0d_timeout_rise", v), 136'(to_off), 136'(64));
      else check($sformatf("v%0d_ready_seen", v), 136'(ready_seen), 136'(1'b0));
      check($sformatf("v%0d_oe_seen", v), 136'(oe_seen), 136'(1'b0));
      check($sformatf("v%0d_busy_end", v), 136'(o_busy), 136'(1'b0));
    end

    // CMD8 with the R7-style short response offered before the command arrives.
    clear_stats();
    i_rsp_long = 1'b0;
    i_rsp_data = {82'd0, 6'd8, 32'h0000_01AA};
    i_rsp_valid = 1'b1;
    send_cmd(48'h48_0000_01AA_87);
    idle(60);
    short_h   = {2'b00, 6'd8, 32'h0000_01AA};
    exp_short = {short_h, ref_crc7({80'd0, short_h}), 1'b1};
    check("cmd8_decode", 136'({valid_cnt[3:0], got_err, got_idx, got_arg}), 136'({4'd1, 1'b0, 6'd8, 32'h0000_01AA}));
    check("cmd8_start_offset", 136'(rsp_start), 136'(3));
    check("cmd8_oe_periods", 136'(rsp_count), 136'(48));
    check("cmd8_frame", 136'(rsp_bits[47:0]), 136'(exp_short));
    check("cmd8_no_timeout", 136'(to_cnt), 136'(0));
    check("cmd8_release", 136'({o_cmd_oe, o_cmd, o_busy}), 136'(3'b010));

    // CMD2 with a 136-bit R2 response: CRC covers the 120 data bits only.
    clear_stats();
    long_d = 120'h23456789ABCDEF0123456789ABCDEF;
    i_rsp_long = 1'b1;
    i_rsp_data = long_d;
    i_rsp_valid = 1'b1;
    send_cmd(mk_cmd(6'd2, 32'h0));
    idle(150);
    exp_long = {2'b00, 6'h3F, long_d, ref_crc7(long_d), 1'b1};
    check("cmd2_start_offset", 136'(rsp_start), 136'(3));
    check("cmd2_oe_periods", 136'(rsp_count), 136'(136));
    check("cmd2_frame", rsp_bits, exp_long);
    check("cmd2_release", 136'({o_cmd_oe, o_cmd, o_busy}), 136'(3'b010));
    i_rsp_long = 1'b0;

    // Reset while the response is mid-frame.
    clear_stats();
    i_rsp_data = {82'd0, 6'd13, 32'h0000_0900};
    i_rsp_valid = 1'b1;
    send_cmd(mk_cmd(6'd13, 32'h0001_0000));
    for (int k = 0; k < 40 && rsp_count < 20; k++) sd_cycle(1'b1);
    check("rst_tx_reached_bit20", 136'(rsp_count), 136'(20));
    cur_cycle++;
    i_cmd = 1'b1;
    i_sd_ck = 1'b0;
    repeat (6) tick();
    check("rst_driving_before", 136'(o_cmd_oe), 136'(1'b1));
    i_reset_n = 1'b0;
    tick();
    check("rst_line_released", 136'({o_cmd_oe, o_cmd, o_busy}), 136'(3'b010));
    repeat (3) tick();
    i_reset_n = 1'b1;
    tick();
    i_sd_ck = 1'b1;
    repeat (8) tick();
    clear_stats();
    send_cmd(mk_cmd(6'd7, 32'h5A5A_0000));
    idle(4);
    check("post_rst_decode", 136'({valid_cnt[3:0], got_err, got_idx, got_arg}), 136'({4'd1, 1'b0, 6'd7, 32'h5A5A_0000}));
    check("post_rst_ready", 136'(ready_after_valid), 136'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
